// File: rtl/output_port_arbiter_pkg.sv
// output_port_arbiter_pkg: port codes, arbiter states and port-index helpers.
package output_port_arbiter_pkg;
  typedef enum logic {IDLE, LOCKED} state_e;
  localparam logic [2:0] NONE_PORT = 3'd0;
  localparam logic [2:0] N_PORT = 3'd1;
  localparam logic [2:0] W_PORT = 3'd2;
  localparam logic [2:0] L_PORT = 3'd3;
  localparam logic [1:0] IDX_N = 2'd0;
  localparam logic [1:0] IDX_W = 2'd1;
  localparam logic [1:0] IDX_L = 2'd2;
  function automatic logic [2:0] port_code(input logic [1:0] idx);
    return idx == IDX_N ? N_PORT : idx == IDX_W ? W_PORT : L_PORT;
  endfunction
endpackage

// File: rtl/output_port_arbiter_rr_priority_picker.sv
// rr_priority_picker: picks the first requester after last in N -> W -> L order.
module rr_priority_picker
  import output_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);
  always_comb begin
    any  = |req;
    pick = last == IDX_N ? (req[IDX_W] ? IDX_W : req[IDX_L] ? IDX_L : IDX_N) :
           last == IDX_W ? (req[IDX_L] ? IDX_L : req[IDX_N] ? IDX_N : IDX_W) :
                           (req[IDX_N] ? IDX_N : req[IDX_W] ? IDX_W : IDX_L);
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: wormhole round-robin lock of one router output among N/W/L inputs.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       N_req,
  input  logic       W_req,
  input  logic       L_req,
  input  logic       N_tail,
  input  logic       W_tail,
  input  logic       L_tail,
  input  logic       out_ready,
  output logic [2:0] sel_out,
  output logic       N_grant,
  output logic       W_grant,
  output logic       L_grant,
  output logic       busy
);
  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d, last_q, last_d, pick;
  logic [2:0] sel_q, sel_d, req, tail, grant;
  logic       any, fire;
  assign req  = {L_req, W_req, N_req};
  assign tail = {L_tail, W_tail, N_tail};
  rr_priority_picker u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );
  // Arbitration only happens from IDLE, so a release always leaves one idle bubble.
  always_comb begin
    grant   = (state_q == LOCKED && out_ready && req[owner_q]) ? 3'b001 << owner_q : 3'b000;
    fire    = |(grant & tail);
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    sel_d   = sel_q;
    if (state_q == IDLE && any) begin
      state_d = LOCKED;
      owner_d = pick;
      sel_d   = port_code(pick);
    end else if (fire) begin
      state_d = IDLE;
      last_d  = owner_q;
      sel_d   = NONE_PORT;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= IDX_L;
      last_q  <= IDX_L;
      sel_q   <= NONE_PORT;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end
  assign {L_grant, W_grant, N_grant} = grant;
  assign sel_out = sel_q;
  assign busy    = state_q == LOCKED;
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: random packet sources vs a queue-based reference model.
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic N_req = 0, W_req = 0, L_req = 0, N_tail = 0, W_tail = 0, L_tail = 0, out_ready = 0;
  logic [2:0] sel_out;
  logic N_grant, W_grant, L_grant, busy;
  logic [6:0] sb[$];
  int checks = 0;
  int passes = 0;
  int locks = 0;
  always #5 clk = ~clk;
  output_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .N_req     (N_req),
    .W_req     (W_req),
    .L_req     (L_req),
    .N_tail    (N_tail),
    .W_tail    (W_tail),
    .L_tail    (L_tail),
    .out_ready (out_ready),
    .sel_out   (sel_out),
    .N_grant   (N_grant),
    .W_grant   (W_grant),
    .L_grant   (L_grant),
    .busy      (busy)
  );
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [6:0] exp_v, act_v;
      exp_v = sb.pop_front();
      act_v = {sel_out, busy, L_grant, W_grant, N_grant};
      checks++;
      if (act_v === exp_v) passes++;
      else $display("FAIL cycle_out t=%0t: sel/busy/LWN_grant got %b_%b_%b, want %b_%b_%b",
                    $time, act_v[6:4], act_v[3], act_v[2:0], exp_v[6:4], exp_v[3], exp_v[2:0]);
    end
  end
  initial begin
    logic [2:0] code[3];
    int rem[3];
    logic [2:0] hold, tl, g;
    logic rdy, rst_v, m_locked;
    int m_owner, m_last;
    code = '{N_PORT, W_PORT, L_PORT};
    rem = '{0, 0, 0};
    m_locked = 0;
    m_owner = 2;
    m_last = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      rst_v = (cyc < 3 || $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      for (int p = 0; p < 3; p++) begin
        if (rem[p] == 0 && $urandom_range(0, 2) == 0) rem[p] = $urandom_range(1, 4);
        hold[p] = rem[p] > 0 && $urandom_range(0, 7) != 0;
        tl[p]   = rem[p] == 1;
      end
      rdy = $urandom_range(0, 3) != 0;
      rst = rst_v;
      {L_req, W_req, N_req} = hold;
      {L_tail, W_tail, N_tail} = tl;
      out_ready = rdy;
      if (!rst_v) begin
        m_locked = 0;
        m_last = 2;
      end
      g = 3'b000;
      if (m_locked && rdy && hold[m_owner]) g[m_owner] = 1'b1;
      sb.push_back({m_locked ? code[m_owner] : NONE_PORT, m_locked, g});
      if (rst_v) begin
        if (!m_locked) begin
          for (int i = 1; i <= 3; i++) begin
            if (!m_locked && hold[(m_last + i) % 3]) begin
              m_locked = 1;
              m_owner = (m_last + i) % 3;
              locks++;
            end
          end
        end else if (g != 0 && tl[m_owner]) begin
          m_locked = 0;
          m_last = m_owner;
        end
      end
      for (int p = 0; p < 3; p++) if (g[p]) rem[p]--;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() == 0 && locks > 50) passes++;
    else $display("FAIL drain: queue left %0d, locks seen %0d, want 0 and >50", sb.size(), locks);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameters: none; flit width not used, only control; port codes N_PORT, W_PORT, L_PORT come from router_3_state_defines.v.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 N_req, W_req, L_req  input  1 each  input port X holds a flit routed to this output.
REQ-005 N_tail, W_tail, L_tail  input  1 each  flit currently offered by X is a tail (or single-flit packet); qualified by X_req.
REQ-006 out_ready  input  1  downstream accepts a flit this cycle.
REQ-007 sel_out  output  3  crossbar select; N_PORT/W_PORT/L_PORT when locked, NONE_PORT when idle.
REQ-008 N_grant, W_grant, L_grant  output  1 each  flit from X transferred this cycle; X pops its buffer.
REQ-009 busy  output  1  packet lock held.

Function
REQ-010 Two states: IDLE, LOCKED; state, owner, sel_out and priority pointer are registers.
REQ-011 IDLE: if any X_req high, next cycle -> LOCKED, owner = first requester in round-robin order starting after last_owner (order N -> W -> L -> N).
REQ-012 IDLE with no requests: remain IDLE, sel_out = NONE_PORT, all grants 0.
REQ-013 Arbitration latency: request in cycle t -> sel_out valid and busy=1 in cycle t+1; earliest grant in t+1.
REQ-014 LOCKED: sel_out = owner code, held constant until release.
REQ-015 X_grant = LOCKED & (owner==X) & X_req & out_ready, combinational from registered state and inputs; at most one grant high.
REQ-016 Non-owner requests ignored while LOCKED (wormhole lock); owner dropping X_req does not release lock.
REQ-017 Release: grant with owner's X_tail=1 -> next cycle IDLE, sel_out = NONE_PORT, last_owner = owner.
REQ-018 No back-to-back re-lock in release cycle; new arbitration earliest one cycle after release (one idle bubble).
REQ-019 Single-flit packet: lock, grant with tail in same cycle, release; owner takes 2 cycles minimum per packet.
REQ-020 out_ready=0 while LOCKED: no grant, state and sel_out unchanged.
REQ-021 Tail with out_ready=0: not a transfer; no release.
REQ-022 Fairness: a continuously requesting port is granted lock within 2 packet times of any competitor.
REQ-023 NONE_PORT shall be an encoding distinct from all port codes so xbar default branch drives validout=0.

Reset
REQ-024 rst low (asynchronous): state=IDLE, sel_out=NONE_PORT, busy=0, last_owner=L (so N has first priority); grants 0 combinationally.
REQ-025 Reset mid-packet discards lock immediately; no grant asserted during reset.
REQ-026 Deassertion: first arbitration on first rising edge with rst high.

Structure
REQ-027 NONE_PORT and IDLE/LOCKED state codes defined in router_3_state_defines.v beside existing port codes.
REQ-028 One sub-module: rr_priority_picker (combinational 3-way round-robin pick from request vector and last_owner).
REQ-029 Instantiated once per router output port; sel_out connects directly to xbar sel_in.

Verification
REQ-030 Reset then only W_req=1, 3-flit packet, out_ready=1 -> sel_out=W_PORT at t+1, W_grant 3 cycles, NONE_PORT after tail.
REQ-031 N_req, W_req, L_req all high after reset, single-flit packets -> lock order N, W, L, N, one idle cycle between.
REQ-032 Owner N locked, out_ready toggles 1,0,0,1 -> N_grant only on ready cycles, sel_out stays N_PORT.
REQ-033 Owner L locked, W_req raised mid-packet -> W_grant=0 until L tail transferred; W locked cycle after release bubble.
REQ-034 rst pulsed low while LOCKED on W -> sel_out=NONE_PORT, busy=0 asynchronously; after release N wins if requesting.
REQ-035 Tail offered with out_ready=0 -> lock retained; released only on subsequent tail grant.
